// File: rtl/strassen_pkg.sv
// Shared encodings for the 2x2 Strassen sequencer: ALU opcodes, mux sources,
// controller states and the per-phase opcode words (alu_1 in the low bits).
package strassen_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MULT = 3'd2;

  localparam logic [1:0] SRC_OPND  = 2'd0;
  localparam logic [1:0] SRC_PRE   = 2'd1;
  localparam logic [1:0] SRC_MUL   = 2'd2;
  localparam logic [1:0] SRC_POST1 = 2'd3;

  localparam logic [CNT_W-1:0] LOAD_LAST  = 4'd8;
  localparam logic [CNT_W-1:0] WRITE_LAST = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRE   = 3'd2,
    S_MUL   = 3'd3,
    S_POST1 = 3'd4,
    S_POST2 = 3'd5,
    S_WRITE = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Listed alu_10 first so the concatenation lands alu_1 at [2:0].
  localparam logic [29:0] OPS_PRE = {ALU_ADD, ALU_SUB, ALU_ADD, ALU_SUB, ALU_ADD,
                                     ALU_ADD, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SUB};
  localparam logic [29:0] OPS_MUL = {3'd0, 3'd0, 3'd0, ALU_MULT, ALU_MULT,
                                     ALU_MULT, ALU_MULT, ALU_MULT, ALU_MULT, ALU_MULT};
  localparam logic [29:0] OPS_POST1 = {3'd0, 3'd0, 3'd0, 3'd0, ALU_ADD,
                                       ALU_ADD, ALU_ADD, ALU_ADD, ALU_SUB, ALU_ADD};
  localparam logic [29:0] OPS_POST2 = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                       ALU_SUB, 3'd0, 3'd0, 3'd0, ALU_ADD};

  function automatic logic [7:0] mux_all(input logic [1:0] src);
    return {4{src}};
  endfunction

endpackage

// File: rtl/strassen_addr_gen.sv
// Phase-local cycle counter plus base+offset address generator, shared by the
// operand reads and the result writes.
module strassen_addr_gen
  import strassen_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [AW-1:0]    a_base,
  input  logic [AW-1:0]    b_base,
  input  logic [AW-1:0]    c_base,
  output logic [AW-1:0]    mem_addr,
  output logic [CNT_W-1:0] idx
);

  logic [CNT_W-1:0] cnt_r;
  logic [AW-1:0]    base_s;
  logic [AW-1:0]    off_s;

  // Counter restarts at 0 on every phase entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // Reads 0..3 hit A and 4..7 hit B, so the offset is always the low two bits.
  always_comb begin
    base_s = a_base;
    if (wr) begin
      base_s = c_base;
    end else if (cnt_r[2]) begin
      base_s = b_base;
    end else begin
      base_s = a_base;
    end
    off_s    = AW'(cnt_r[1:0]);
    mem_addr = base_s + off_s;
    idx      = cnt_r;
  end

endmodule

// File: rtl/strassen_ctrl.sv
// Start-triggered sequencer for one 2x2 Strassen block multiply: operand load,
// pre-add, multiply, two post-add stages and result write-back.
module strassen_ctrl
  import strassen_pkg::*;
#(
  parameter int AW      = 8,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [1:0]    wr_sel,
  output logic          opnd_ld,
  output logic [2:0]    opnd_idx,
  output logic [29:0]   alu_op,
  output logic [7:0]    mux_sel,
  output logic [3:0]    cap
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  state_t           state_r, state_s;
  logic [AW-1:0]    a_base_r, b_base_r, c_base_r;
  logic [AW-1:0]    gen_addr_s;
  logic [CNT_W-1:0] idx_s;
  logic             clr_s;
  logic             wr_phase_s;

  strassen_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .wr       (wr_phase_s),
    .a_base   (a_base_r),
    .b_base   (b_base_r),
    .c_base   (c_base_r),
    .mem_addr (gen_addr_s),
    .idx      (idx_s)
  );

  // State register and base capture on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      a_base_r <= '0;
      b_base_r <= '0;
      c_base_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == S_IDLE && start) begin
        a_base_r <= a_base;
        b_base_r <= b_base;
        c_base_r <= c_base;
      end else begin
        a_base_r <= a_base_r;
        b_base_r <= b_base_r;
        c_base_r <= c_base_r;
      end
    end
  end

  // Next-state logic; the phase counter clears whenever a new phase begins.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_s = (idx_s == LOAD_LAST) ? S_PRE : S_LOAD;
      S_PRE:   state_s = S_MUL;
      S_MUL:   state_s = (idx_s == MUL_LAST) ? S_POST1 : S_MUL;
      S_POST1: state_s = S_POST2;
      S_POST2: state_s = S_WRITE;
      S_WRITE: state_s = (idx_s == WRITE_LAST) ? S_DONE : S_WRITE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    clr_s      = (state_s != state_r) || (state_r == S_IDLE);
    wr_phase_s = (state_r == S_WRITE);
  end

  // Output decode from state and phase counter only.
  always_comb begin
    busy     = (state_r != S_IDLE);
    done     = 1'b0;
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    wr_sel   = 2'd0;
    opnd_ld  = 1'b0;
    opnd_idx = 3'd0;
    alu_op   = 30'd0;
    mux_sel  = 8'd0;
    cap      = 4'b0000;
    case (state_r)
      S_LOAD: begin
        if (idx_s < LOAD_LAST) begin
          mem_re   = 1'b1;
          mem_addr = gen_addr_s;
        end else begin
          mem_re   = 1'b0;
          mem_addr = '0;
        end
        // Read data lags the strobe by one cycle, so the load index trails by one.
        if (idx_s != 4'd0) begin
          opnd_ld  = 1'b1;
          opnd_idx = 3'(idx_s - 4'd1);
        end else begin
          opnd_ld  = 1'b0;
          opnd_idx = 3'd0;
        end
      end
      S_PRE: begin
        alu_op  = OPS_PRE;
        mux_sel = mux_all(SRC_OPND);
        cap     = 4'b0001;
      end
      S_MUL: begin
        alu_op  = OPS_MUL;
        mux_sel = mux_all(SRC_PRE);
        cap     = (idx_s == MUL_LAST) ? 4'b0010 : 4'b0000;
      end
      S_POST1: begin
        alu_op  = OPS_POST1;
        mux_sel = mux_all(SRC_MUL);
        cap     = 4'b0100;
      end
      S_POST2: begin
        alu_op  = OPS_POST2;
        mux_sel = mux_all(SRC_POST1);
        cap     = 4'b1000;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = gen_addr_s;
        wr_sel   = idx_s[1:0];
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_strassen_ctrl.sv
// Bench for strassen_ctrl: directed cycle table, randomized runs against a
// timeline model, a word-memory/datapath model and handshake/reset corners.
module tb_strassen_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  a_base, b_base, c_base;

  logic        busy, done, mem_re, mem_we, opnd_ld;
  logic [7:0]  mem_addr, mux_sel;
  logic [1:0]  wr_sel;
  logic [2:0]  opnd_idx;
  logic [29:0] alu_op;
  logic [3:0]  cap;

  logic        busy4, done4, mem_re4, mem_we4, opnd_ld4;
  logic [7:0]  mem_addr4, mux_sel4;
  logic [1:0]  wr_sel4;
  logic [2:0]  opnd_idx4;
  logic [29:0] alu_op4;
  logic [3:0]  cap4;

  strassen_ctrl #(.AW(8), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .wr_sel(wr_sel), .opnd_ld(opnd_ld), .opnd_idx(opnd_idx), .alu_op(alu_op),
    .mux_sel(mux_sel), .cap(cap));

  strassen_ctrl #(.AW(8), .MUL_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy4), .done(done4), .mem_addr(mem_addr4), .mem_re(mem_re4), .mem_we(mem_we4),
    .wr_sel(wr_sel4), .opnd_ld(opnd_ld4), .opnd_idx(opnd_idx4), .alu_op(alu_op4),
    .mux_sel(mux_sel4), .cap(cap4));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        re;
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  ws;
    logic        ld;
    logic [2:0]  idx;
    logic [29:0] op;
    logic [7:0]  mux;
    logic [3:0]  cap;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t e;
  } row_t;

  int checks = 0;
  int errors = 0;

  // Word memory plus datapath model, driven by the lat-2 controller's strobes.
  int   mem [0:255];
  int   rdata;
  int   opr [0:7];
  int   s [1:10];
  int   m [1:7];
  int   p [1:6];
  int   cw [0:3];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  int         tb_data = 0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr] <= cw[wr_sel];
    if (mem_re) rdata <= mem[mem_addr];
    if (opnd_ld) opr[opnd_idx] <= rdata;
    if (cap[0]) begin
      s[1] <= opr[5] - opr[7];  s[2] <= opr[0] + opr[1];
      s[3] <= opr[2] + opr[3];  s[4] <= opr[6] - opr[4];
      s[5] <= opr[0] + opr[3];  s[6] <= opr[4] + opr[7];
      s[7] <= opr[1] - opr[3];  s[8] <= opr[6] + opr[7];
      s[9] <= opr[0] - opr[2];  s[10] <= opr[4] + opr[5];
    end
    if (cap[1]) begin
      m[1] <= opr[0] * s[1]; m[2] <= s[2] * opr[7]; m[3] <= s[3] * opr[4];
      m[4] <= opr[3] * s[4]; m[5] <= s[5] * s[6];   m[6] <= s[7] * s[8];
      m[7] <= s[9] * s[10];
    end
    if (cap[2]) begin
      p[1] <= m[5] + m[4]; p[2] <= m[6] - m[2]; cw[1] <= m[1] + m[2];
      cw[2] <= m[3] + m[4]; p[5] <= m[5] + m[1]; p[6] <= m[3] + m[7];
    end
    if (cap[3]) begin
      cw[0] <= p[1] + p[2];
      cw[3] <= p[5] - p[6];
    end
  end

  // Opcode word from a 10-char string, alu_1 first: A=add, S=sub, M=mult, -=0.
  function automatic logic [29:0] ops(input string str);
    logic [29:0] r = 30'd0;
    for (int k = 0; k < 10; k++) begin
      if (str.getc(k) == "S") r[3*k +: 3] = 3'd1;
      else if (str.getc(k) == "M") r[3*k +: 3] = 3'd2;
    end
    return r;
  endfunction

  function automatic outs_t mk(int bz, int dn, int re, int we, int addr, int ws, int ld,
                               int idx, logic [29:0] op, logic [7:0] mux, logic [3:0] cp);
    outs_t o;
    o.busy = (bz != 0); o.done = (dn != 0); o.re = (re != 0); o.we = (we != 0);
    o.addr = 8'(addr); o.ws = 2'(ws); o.ld = (ld != 0); o.idx = 3'(idx);
    o.op = op; o.mux = mux; o.cap = cp;
    return o;
  endfunction

  // Expected outputs t cycles after start acceptance, from the phase timeline.
  function automatic outs_t exp_out(int t, logic [7:0] a, logic [7:0] b, logic [7:0] c, int lat);
    outs_t o = '0;
    int k;
    if (t >= 1 && t <= 17 + lat) o.busy = 1'b1;
    if (t >= 1 && t <= 9) begin
      k = t - 1;
      if (k < 8) begin
        o.re = 1'b1;
        o.addr = (k < 4) ? a + 8'(k) : b + 8'(k - 4);
      end
      if (k >= 1) begin
        o.ld = 1'b1;
        o.idx = 3'(k - 1);
      end
    end else if (t == 10) begin
      o.op = ops("SAASAASASA"); o.cap = 4'b0001;
    end else if (t >= 11 && t <= 10 + lat) begin
      o.op = ops("MMMMMMM---"); o.mux = 8'h55;
      o.cap = (t == 10 + lat) ? 4'b0010 : 4'b0000;
    end else if (t == 11 + lat) begin
      o.op = ops("ASAAAA----"); o.mux = 8'hAA; o.cap = 4'b0100;
    end else if (t == 12 + lat) begin
      o.op = ops("A---S-----"); o.mux = 8'hFF; o.cap = 4'b1000;
    end else if (t >= 13 + lat && t <= 16 + lat) begin
      o.we = 1'b1; o.addr = c + 8'(t - 13 - lat); o.ws = 2'(t - 13 - lat);
    end else if (t == 17 + lat) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic outs_t samp2();
    return mk(int'(busy), int'(done), int'(mem_re), int'(mem_we), int'(mem_addr), int'(wr_sel),
              int'(opnd_ld), int'(opnd_idx), alu_op, mux_sel, cap);
  endfunction

  function automatic outs_t samp4();
    return mk(int'(busy4), int'(done4), int'(mem_re4), int'(mem_we4), int'(mem_addr4),
              int'(wr_sel4), int'(opnd_ld4), int'(opnd_idx4), alu_op4, mux_sel4, cap4);
  endfunction

  task automatic chk(input string name, input int t, input outs_t got, input outs_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, e);
    end
  endtask

  task automatic chk_int(input string name, input int t, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", name, t, got, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_put(input logic [7:0] addr, input int data);
    tb_we = 1'b1; tb_addr = addr; tb_data = data;
    step();
    tb_we = 1'b0;
  endtask

  // Plain 2x2 matrix product of what memory holds at the A and B bases.
  task automatic check_c(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input int av[4], input int bv[4]);
    int e[4];
    e[0] = av[0] * bv[0] + av[1] * bv[2];
    e[1] = av[0] * bv[1] + av[1] * bv[3];
    e[2] = av[2] * bv[0] + av[3] * bv[2];
    e[3] = av[2] * bv[1] + av[3] * bv[3];
    for (int j = 0; j < 4; j++) chk_int("c_word", j, mem[c + 8'(j)], e[j]);
  endtask

  row_t tbl [17];
  int   av[4], bv[4];
  int   t;

  initial begin
    tbl[0]  = '{0,  mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[1]  = '{1,  mk(1, 0, 1, 0, 8'h10, 0, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[2]  = '{4,  mk(1, 0, 1, 0, 8'h13, 0, 1, 2, 30'd0, 8'h00, 4'h0)};
    tbl[3]  = '{5,  mk(1, 0, 1, 0, 8'h20, 0, 1, 3, 30'd0, 8'h00, 4'h0)};
    tbl[4]  = '{8,  mk(1, 0, 1, 0, 8'h23, 0, 1, 6, 30'd0, 8'h00, 4'h0)};
    tbl[5]  = '{9,  mk(1, 0, 0, 0, 8'h00, 0, 1, 7, 30'd0, 8'h00, 4'h0)};
    tbl[6]  = '{10, mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 30'h01040201, 8'h00, 4'h1)};
    tbl[7]  = '{11, mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 30'h00092492, 8'h55, 4'h0)};
    tbl[8]  = '{12, mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 30'h00092492, 8'h55, 4'h2)};
    tbl[9]  = '{13, mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 30'h00000008, 8'hAA, 4'h4)};
    tbl[10] = '{14, mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 30'h00001000, 8'hFF, 4'h8)};
    tbl[11] = '{15, mk(1, 0, 0, 1, 8'h30, 0, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[12] = '{16, mk(1, 0, 0, 1, 8'h31, 1, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[13] = '{17, mk(1, 0, 0, 1, 8'h32, 2, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[14] = '{18, mk(1, 0, 0, 1, 8'h33, 3, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[15] = '{19, mk(1, 1, 0, 0, 8'h00, 0, 0, 0, 30'd0, 8'h00, 4'h0)};
    tbl[16] = '{20, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 30'd0, 8'h00, 4'h0)};

    rst = 1'b1; start = 1'b0; a_base = 8'h00; b_base = 8'h00; c_base = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("reset_idle", i, samp2(), '0);
      chk("reset_idle4", i, samp4(), '0);
      step();
    end

    // Directed run through the cycle table, then the known-answer product.
    for (int i = 0; i < 4; i++) mem_put(8'h10 + 8'(i), i + 1);
    for (int i = 0; i < 4; i++) mem_put(8'h20 + 8'(i), i + 5);
    a_base = 8'h10; b_base = 8'h20; c_base = 8'h30;
    start = 1'b1; t = 0;
    for (int i = 0; i < 17; i++) begin
      while (t < tbl[i].cyc) begin
        step(); t++; start = 1'b0;
      end
      chk("table", t, samp2(), tbl[i].e);
    end
    while (t < 23) begin step(); t++; end
    av = '{1, 2, 3, 4}; bv = '{5, 6, 7, 8};
    check_c(8'h10, 8'h20, 8'h30, av, bv);

    // Randomized bases and operands; first pass forces the C wrap at 0xFE.
    for (int n = 0; n < 6; n++) begin
      a_base = 8'($urandom_range(0, 255));
      b_base = 8'($urandom_range(0, 255));
      c_base = (n == 0) ? 8'hFE : 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) mem_put(a_base + 8'(i), int'($urandom_range(0, 30)) - 15);
      for (int i = 0; i < 4; i++) mem_put(b_base + 8'(i), int'($urandom_range(0, 30)) - 15);
      for (int i = 0; i < 4; i++) begin
        av[i] = mem[a_base + 8'(i)];
        bv[i] = mem[b_base + 8'(i)];
      end
      for (int tt = 0; tt <= 22; tt++) begin
        start = (tt == 0);
        chk("rand_lat2", tt, samp2(), exp_out(tt, a_base, b_base, c_base, 2));
        chk("rand_lat4", tt, samp4(), exp_out(tt, a_base, b_base, c_base, 4));
        step();
      end
      check_c(a_base, b_base, c_base, av, bv);
    end

    // start pulses while busy and in DONE are dropped.
    for (int tt = 0; tt <= 45; tt++) begin
      start = (tt == 0 || tt == 5 || tt == 19);
      chk_int("ignore_done", tt, int'(done), int'(tt == 19));
      chk_int("ignore_done4", tt, int'(done4), int'(tt == 21));
      step();
    end

    // start held high: back-to-back runs, done every 20 cycles.
    for (int tt = 0; tt < 60; tt++) begin
      start = 1'b1;
      chk_int("held_done", tt, int'(done), int'(tt % 20 == 19));
      step();
    end
    start = 1'b0;
    repeat (30) step();

    // Reset in the middle of WRITE.
    for (int tt = 0; tt <= 16; tt++) begin
      start = (tt == 0);
      if (tt == 16) begin
        chk_int("pre_rst_we", tt, int'(mem_we), 1);
        rst = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    for (int tt = 17; tt <= 40; tt++) begin
      chk("after_rst", tt, samp2(), '0);
      chk("after_rst4", tt, samp4(), '0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
